// File: rtl/fir_stage_scheduler.sv
// fir_stage_scheduler
// Shares one FIR multiply-accumulate engine across NUM_STAGES cascaded
// decimation stages. Each stage has a one-deep pending slot; the deepest
// pending stage wins the engine so the cascade drains before new input is
// accepted. Compute results are forwarded into the next stage's slot, or out
// of the block from the last stage.
//
// Build option: define OVERRUN_COUNT_EN to build the sticky overrun flag and
// the saturating overrun counter. Without it both outputs are tied to 0.
// Overwrite-on-overrun data behaviour is identical in both builds.
//
// Engine handshake: eng_start is a one-cycle command. eng_stage, eng_sample
// and eng_compute are stable from eng_start until eng_done. eng_done is a
// one-cycle completion that is only accepted while the FSM is in S_WAIT;
// eng_result is taken with eng_done when eng_compute is 1.
module fir_stage_scheduler #(
  parameter int NUM_STAGES   = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int DECIM_FACTOR = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic signed [DATA_WIDTH-1:0]  sample_in,
  input  logic                          sample_valid_in,
  output logic                          eng_start,
  output logic [$clog2(NUM_STAGES)-1:0] eng_stage,
  output logic signed [DATA_WIDTH-1:0]  eng_sample,
  output logic                          eng_compute,
  input  logic                          eng_done,
  input  logic signed [DATA_WIDTH-1:0]  eng_result,
  output logic signed [DATA_WIDTH-1:0]  sample_out,
  output logic                          sample_valid_out,
  output logic                          overrun,
  output logic [7:0]                    overrun_count
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam int PW = $clog2(DECIM_FACTOR);
  localparam logic [PW-1:0] PH_LAST = PW'(DECIM_FACTOR - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_STAGES-1:0]        pend_q, pend_d, set_ev, clr_ev;
  logic signed [DATA_WIDTH-1:0] hold_q  [NUM_STAGES];
  logic signed [DATA_WIDTH-1:0] hold_d  [NUM_STAGES];
  logic [PW-1:0]                phase_q [NUM_STAGES];
  logic [PW-1:0]                phase_d [NUM_STAGES];

  logic [SW-1:0] grant_idx;
  logic          any_pend, grant_fire, done_fire, wb_fire;

  logic                         eng_start_q, eng_start_d;
  logic [SW-1:0]                eng_stage_q, eng_stage_d;
  logic signed [DATA_WIDTH-1:0] eng_sample_q, eng_sample_d;
  logic                         eng_compute_q, eng_compute_d;
  logic signed [DATA_WIDTH-1:0] sample_out_q, sample_out_d;
  logic                         sample_valid_q, sample_valid_d;

  // Fixed priority: the highest pending index wins (deepest stage first).
  always_comb begin
    grant_idx = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (pend_q[s]) grant_idx = SW'(s);
    end
  end

  assign any_pend   = |pend_q;
  assign grant_fire = (state_q == S_IDLE) && any_pend;
  assign done_fire  = (state_q == S_WAIT) && eng_done;
  assign wb_fire    = done_fire && eng_compute_q;

  // Slot set/clear events; a set in the same cycle as a clear keeps the slot.
  always_comb begin
    set_ev = '0;
    clr_ev = '0;
    pend_d = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      hold_d[s] = hold_q[s];
      if (s == 0) set_ev[s] = sample_valid_in;
      else        set_ev[s] = wb_fire && (eng_stage_q == SW'(s - 1));
      clr_ev[s] = grant_fire && (grant_idx == SW'(s));
      if (set_ev[s]) hold_d[s] = (s == 0) ? sample_in : eng_result;
      pend_d[s] = set_ev[s] | (pend_q[s] & ~clr_ev[s]);
    end
  end

  // Decimation phase of the stage just serviced advances on completion.
  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) begin
      phase_d[s] = phase_q[s];
      if (done_fire && (eng_stage_q == SW'(s))) begin
        phase_d[s] = (phase_q[s] == PH_LAST) ? '0 : phase_q[s] + PW'(1);
      end
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_pend) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (eng_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: job fields are captured at grant and held until the next grant.
  always_comb begin
    eng_start_d    = grant_fire;
    eng_stage_d    = eng_stage_q;
    eng_sample_d   = eng_sample_q;
    eng_compute_d  = eng_compute_q;
    if (grant_fire) begin
      eng_stage_d   = grant_idx;
      eng_sample_d  = hold_q[grant_idx];
      eng_compute_d = (phase_q[grant_idx] == PH_LAST);
    end
    sample_valid_d = wb_fire && (eng_stage_q == ST_LAST);
    sample_out_d   = sample_valid_d ? eng_result : sample_out_q;
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Per-stage slots, holding registers and phase counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_q <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        hold_q[s]  <= '0;
        phase_q[s] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      for (int s = 0; s < NUM_STAGES; s++) begin
        hold_q[s]  <= hold_d[s];
        phase_q[s] <= phase_d[s];
      end
    end
  end

  // Registered engine command and cascade output.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      eng_start_q    <= 1'b0;
      eng_stage_q    <= '0;
      eng_sample_q   <= '0;
      eng_compute_q  <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      eng_start_q    <= eng_start_d;
      eng_stage_q    <= eng_stage_d;
      eng_sample_q   <= eng_sample_d;
      eng_compute_q  <= eng_compute_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign eng_start        = eng_start_q;
  assign eng_stage        = eng_stage_q;
  assign eng_sample       = eng_sample_q;
  assign eng_compute      = eng_compute_q;
  assign sample_out       = sample_out_q;
  assign sample_valid_out = sample_valid_q;

`ifdef OVERRUN_COUNT_EN
  logic [NUM_STAGES-1:0] ovr_ev;
  logic                  overrun_q, overrun_d;
  logic [7:0]            ovr_cnt_q, ovr_cnt_d;
  logic [15:0]           ovr_total;

  // Overrun = set on an already-pending slot that is not being granted now.
  always_comb begin
    ovr_ev    = set_ev & pend_q & ~clr_ev;
    ovr_total = {8'd0, ovr_cnt_q};
    for (int s = 0; s < NUM_STAGES; s++) begin
      ovr_total = ovr_total + 16'(ovr_ev[s]);
    end
    ovr_cnt_d = (ovr_total > 16'd255) ? 8'hFF : ovr_total[7:0];
    overrun_d = overrun_q | (|ovr_ev);
  end

  // Sticky flag and saturating event counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      overrun_q <= overrun_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign overrun       = overrun_q;
  assign overrun_count = ovr_cnt_q;
`else
  assign overrun       = 1'b0;
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_fir_stage_scheduler.sv
// tb_fir_stage_scheduler
// Self-checking bench for fir_stage_scheduler (NUM_STAGES=4, DECIM_FACTOR=2).
// The engine model returns eng_sample+1, five cycles after eng_start.
module tb_fir_stage_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int DF = 2;

`ifdef OVERRUN_COUNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]    stage;
    logic [DW-1:0] samp;
    logic          comp;
  } job_t;

  typedef struct {
    logic [DW-1:0] data;
    bit            comp;
    int            jobs;
    int            outs;
    logic [DW-1:0] outv;
  } vec_t;

  logic          clk_in, rst_in;
  logic [DW-1:0] sample_in;
  logic          sample_valid_in;
  logic          eng_start;
  logic [1:0]    eng_stage;
  logic [DW-1:0] eng_sample;
  logic          eng_compute;
  logic          eng_done;
  logic [DW-1:0] eng_result;
  logic [DW-1:0] sample_out;
  logic          sample_valid_out;
  logic          overrun;
  logic [7:0]    overrun_count;

  job_t          job_log[$];
  logic [DW-1:0] out_log[$];
  job_t          exp_jobs[$];
  logic [DW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  bit eng_auto = 1'b1;

  fir_stage_scheduler #(
    .NUM_STAGES(N), .DATA_WIDTH(DW), .DECIM_FACTOR(DF)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .eng_start(eng_start), .eng_stage(eng_stage), .eng_sample(eng_sample),
    .eng_compute(eng_compute), .eng_done(eng_done), .eng_result(eng_result),
    .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .overrun(overrun), .overrun_count(overrun_count)
  );

  // Clock and watchdog
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Engine model: latches the job at eng_start, answers 5 cycles later.
  initial begin
    int            cnt;
    bit            busy;
    logic [DW-1:0] lat;
    cnt = 0; busy = 1'b0; lat = '0;
    eng_done = 1'b0; eng_result = '0;
    forever begin
      @(posedge clk_in); #1;
      eng_done = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy       = 1'b0;
          eng_done   = 1'b1;
          eng_result = lat + 16'd1;
        end
      end else if (eng_start && eng_auto) begin
        busy = 1'b1;
        cnt  = 5;
        lat  = eng_sample;
      end
    end
  end

  // Monitor: logs every issued job and every cascade output.
  always @(negedge clk_in) begin
    job_t j;
    if (eng_start) begin
      j.stage = eng_stage;
      j.samp  = eng_sample;
      j.comp  = eng_compute;
      job_log.push_back(j);
    end
    if (sample_valid_out) out_log.push_back(sample_out);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    sample_valid_in = 1'b0;
    sample_in = '0;
    cycles(3);
    rst_in = 1'b0;
    cycles(2);
    job_log.delete();
    out_log.delete();
  endtask

  task automatic send(input logic [DW-1:0] v);
    @(negedge clk_in);
    sample_in = v;
    sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  task automatic wait_start(output int lat, input int limit);
    lat = 0;
    do begin
      @(negedge clk_in);
      lat++;
    end while (!eng_start && lat < limit);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_stage"}, eng_stage, 0);
    chk({tag, "_eng_sample"}, eng_sample, 0);
    chk({tag, "_eng_compute"}, eng_compute, 0);
    chk({tag, "_sample_out"}, sample_out, 0);
    chk({tag, "_sample_valid_out"}, sample_valid_out, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_overrun_count"}, overrun_count, 0);
  endtask

  function automatic job_t job_at(int idx);
    if (idx < job_log.size()) return job_log[idx];
    return '0;
  endfunction

  function automatic int stage_jobs(int s);
    int c = 0;
    foreach (job_log[k]) if (job_log[k].stage == 2'(s)) c++;
    return c;
  endfunction

  vec_t          vt[16];
  logic [DW-1:0] xs[$];
  logic [DW-1:0] cur[$];
  logic [DW-1:0] nxt[$];
  job_t          act_sel[$];
  job_t          exp_sel[$];

  initial begin
    int            lat, j0, o0, w, nout;
    logic [DW-1:0] a, b, c, ev;
    job_t          jt;

    // Expected per-sample outcome of a widely spaced 16-sample run.
    vt[0]  = '{16'h0100, 1'b0, 1, 0, 16'h0000};
    vt[1]  = '{16'h0203, 1'b1, 2, 0, 16'h0000};
    vt[2]  = '{16'h1111, 1'b0, 1, 0, 16'h0000};
    vt[3]  = '{16'hfff0, 1'b1, 3, 0, 16'h0000};
    vt[4]  = '{16'h0042, 1'b0, 1, 0, 16'h0000};
    vt[5]  = '{16'h8000, 1'b1, 2, 0, 16'h0000};
    vt[6]  = '{16'h7fff, 1'b0, 1, 0, 16'h0000};
    vt[7]  = '{16'h1234, 1'b1, 4, 0, 16'h0000};
    vt[8]  = '{16'h0001, 1'b0, 1, 0, 16'h0000};
    vt[9]  = '{16'habcd, 1'b1, 2, 0, 16'h0000};
    vt[10] = '{16'h5555, 1'b0, 1, 0, 16'h0000};
    vt[11] = '{16'h00ff, 1'b1, 3, 0, 16'h0000};
    vt[12] = '{16'hcafe, 1'b0, 1, 0, 16'h0000};
    vt[13] = '{16'h0f0f, 1'b1, 2, 0, 16'h0000};
    vt[14] = '{16'h3c3c, 1'b0, 1, 0, 16'h0000};
    vt[15] = '{16'h7ffe, 1'b1, 4, 1, 16'h8002};

    // Reset state, checked while reset is held
    rst_in = 1'b0;
    sample_valid_in = 1'b0;
    sample_in = '0;
    #1 rst_in = 1'b1;
    cycles(3);
    check_idle_outputs("reset");
    rst_in = 1'b0;
    cycles(2);
    job_log.delete();
    out_log.delete();

    // Table: 16 samples, 64 cycles apart
    for (int i = 0; i < 16; i++) begin
      j0 = job_log.size();
      o0 = out_log.size();
      @(negedge clk_in);
      sample_in = vt[i].data;
      sample_valid_in = 1'b1;
      @(negedge clk_in);
      sample_valid_in = 1'b0;
      lat = 1;
      while (!eng_start && lat < 20) begin
        @(negedge clk_in);
        lat++;
      end
      chk($sformatf("tbl%0d_latency", i), lat, 2);
      chk($sformatf("tbl%0d_stage", i), eng_stage, 0);
      chk($sformatf("tbl%0d_sample", i), eng_sample, vt[i].data);
      chk($sformatf("tbl%0d_compute", i), eng_compute, vt[i].comp);
      cycles(62);
      chk($sformatf("tbl%0d_jobs", i), job_log.size() - j0, vt[i].jobs);
      chk($sformatf("tbl%0d_outs", i), out_log.size() - o0, vt[i].outs);
      if (vt[i].outs > 0 && out_log.size() > o0)
        chk($sformatf("tbl%0d_outv", i), out_log[o0], vt[i].outv);
    end
    for (int s = 0; s < N; s++)
      chk($sformatf("tbl_jobs_stage%0d", s), stage_jobs(s), 16 >> s);
    chk("tbl_overrun", overrun, 0);
    chk("tbl_overrun_count", overrun_count, 0);

    // Random samples, randomly spaced, against a decimation-chain model
    do_reset();
    xs.delete();
    for (int k = 0; k < 40; k++) begin
      xs.push_back(16'($urandom_range(0, 65535)));
      send(xs[k]);
      cycles($urandom_range(48, 80));
    end
    // Stage s sees every input of stage s-1 whose index is DF-1 mod DF, plus one.
    exp_jobs.delete();
    cur = xs;
    for (int s = 0; s < N; s++) begin
      nxt.delete();
      for (int k = 0; k < cur.size(); k++) begin
        jt.stage = 2'(s);
        jt.samp  = cur[k];
        jt.comp  = ((k % DF) == DF - 1);
        exp_jobs.push_back(jt);
        if (jt.comp) nxt.push_back(cur[k] + 16'd1);
      end
      cur = nxt;
    end
    exp_q = cur;
    for (int s = 0; s < N; s++) begin
      act_sel.delete();
      exp_sel.delete();
      foreach (job_log[k]) if (job_log[k].stage == 2'(s)) act_sel.push_back(job_log[k]);
      foreach (exp_jobs[k]) if (exp_jobs[k].stage == 2'(s)) exp_sel.push_back(exp_jobs[k]);
      chk($sformatf("rnd_jobs_s%0d", s), act_sel.size(), exp_sel.size());
      for (int k = 0; k < exp_sel.size() && k < act_sel.size(); k++) begin
        chk($sformatf("rnd_s%0d_j%0d_sample", s, k), act_sel[k].samp, exp_sel[k].samp);
        chk($sformatf("rnd_s%0d_j%0d_compute", s, k), act_sel[k].comp, exp_sel[k].comp);
      end
    end
    chk("rnd_outs", out_log.size(), exp_q.size());
    nout = 0;
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      if (nout < out_log.size()) chk($sformatf("rnd_out%0d", nout), out_log[nout], ev);
      nout++;
    end
    chk("rnd_overrun", overrun, 0);

    // Overrun: two samples 2 cycles apart while the engine is busy
    do_reset();
    a = 16'h1000; b = 16'h2000; c = 16'h3000;
    send(a);
    wait_start(lat, 20);
    chk("ovr_first_start", eng_start, 1);
    @(negedge clk_in);
    sample_in = b; sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    sample_in = c; sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    cycles(40);
    chk("ovr_flag", overrun, OVR_EN ? 1 : 0);
    chk("ovr_count", overrun_count, OVR_EN ? 1 : 0);
    chk("ovr_jobs", job_log.size(), 3);
    chk("ovr_job1_sample", job_at(1).samp, c);
    chk("ovr_job1_compute", job_at(1).comp, 1);
    chk("ovr_job2_stage", job_at(2).stage, 1);
    chk("ovr_job2_sample", job_at(2).samp, c + 16'd1);

    // Saturation: engine stalled, slot 0 hammered every cycle
    do_reset();
    eng_auto = 1'b0;
    send(16'h0abc);
    cycles(10);
    for (int k = 0; k < 200; k++) begin
      sample_in = 16'(k);
      sample_valid_in = 1'b1;
      @(negedge clk_in);
    end
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    chk("sat_count_199", overrun_count, OVR_EN ? 199 : 0);
    for (int k = 0; k < 100; k++) begin
      sample_in = 16'(k);
      sample_valid_in = 1'b1;
      @(negedge clk_in);
    end
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    chk("sat_count_255", overrun_count, OVR_EN ? 255 : 0);
    chk("sat_flag", overrun, OVR_EN ? 1 : 0);
    do_reset();
    eng_auto = 1'b1;
    chk("sat_reset_flag", overrun, 0);
    chk("sat_reset_count", overrun_count, 0);

    // Sample lands in the same cycle slot 0 is granted
    a = 16'h4444; b = 16'h5555;
    @(negedge clk_in);
    sample_in = a; sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_in = b;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    cycles(40);
    chk("same_overrun", overrun, 0);
    chk("same_jobs", job_log.size(), 3);
    chk("same_job0_sample", job_at(0).samp, a);
    chk("same_job1_stage", job_at(1).stage, 0);
    chk("same_job1_sample", job_at(1).samp, b);
    chk("same_job2_sample", job_at(2).samp, b + 16'd1);

    // Stage-0 input in the same cycle as a write-back into stage 1
    do_reset();
    a = 16'h0011; b = 16'h0022; c = 16'h0033;
    send(a);
    cycles(20);
    send(b);
    w = 0;
    while (!eng_done && w < 30) begin
      @(negedge clk_in);
      w++;
    end
    chk("prio_done_seen", eng_done, 1);
    sample_in = c; sample_valid_in = 1'b1;
    @(negedge clk_in);
    sample_valid_in = 1'b0;
    wait_start(lat, 20);
    chk("prio_first_latency", lat, 1);
    chk("prio_first_stage", eng_stage, 1);
    chk("prio_first_sample", eng_sample, b + 16'd1);
    wait_start(lat, 30);
    chk("prio_second_stage", eng_stage, 0);
    chk("prio_second_sample", eng_sample, c);
    cycles(30);
    chk("prio_overrun", overrun, 0);

    // Reset during WAIT of the last-stage compute job
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send(vt[i].data);
      cycles(62);
    end
    send(vt[15].data);
    w = 0;
    while (!(eng_start && eng_stage == 2'd3 && eng_compute) && w < 60) begin
      @(negedge clk_in);
      w++;
    end
    chk("rst_last_job_seen", eng_start && eng_stage == 2'd3 && eng_compute, 1);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    job_log.delete();
    out_log.delete();
    cycles(20);
    chk("rst_no_output", out_log.size(), 0);
    chk("rst_no_jobs", job_log.size(), 0);
    check_idle_outputs("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
